mem_port_arbiter: RTL and testbench

Two-requester front end for the unified single-port instruction/data memory (8192 x 32-bit words, 13-bit word address, write-or-read per cycle, one-cycle registered read). The block sits between the CPU's fetch unit and its load/store unit and the memory port. It arbitrates one access per slot, converts byte addresses to word addresses, and returns read data with a single-cycle valid pulse.

---
 rtl/mem_port_if.sv | 38 +++
 rtl/mem_port_arbiter.sv | 108 ++++++++++
 tb/tb_mem_port_arbiter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_if.sv
// Bundles the fetch, load/store and memory-port signals of mem_port_arbiter.
// slave is the arbiter's view; master is the requesters' and memory's view.
interface mem_port_if #(
  parameter int unsigned ADDR_W = 13
);
  localparam int unsigned DATA_W = 32;

  logic              if_req;
  logic [DATA_W-1:0] if_addr;
  logic              if_valid;
  logic [DATA_W-1:0] if_data;
  logic              if_err;

  logic              d_req;
  logic              d_we;
  logic [DATA_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_valid;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
    output if_valid, if_data, if_err, d_valid, d_rdata, d_err,
           mem_we, mem_addr, mem_din
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
    input  if_valid, if_data, if_err, d_valid, d_rdata, d_err,
           mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch / load-store arbiter for the single-port unified memory, one access per slot.
// Optional MEM_ADDR_CHECK_EN rejects misaligned or out-of-range byte addresses.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 13
) (
  input logic       clk,
  input logic       rst_n,
  mem_port_if.slave bus
);
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
  typedef enum logic {GRANT_I, GRANT_D} grant_t;

  state_t            state_q, state_d;
  grant_t            last_q, last_d;
  logic              armed_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              d_we_q, d_we_d;
  logic              err_q, err_d;
  logic              i_try, d_try, grant_i, grant_d, mem_we_c;
  logic              if_bad, d_bad;
  logic              i_resp, d_resp;

`ifdef MEM_ADDR_CHECK_EN
  assign if_bad = (bus.if_addr[1:0] != 2'b00) || (bus.if_addr[DATA_W-1:ADDR_W+2] != '0);
  assign d_bad  = (bus.d_addr[1:0]  != 2'b00) || (bus.d_addr[DATA_W-1:ADDR_W+2]  != '0);
`else
  // Byte-offset and upper address bits are don't-care: accesses alias modulo the memory size.
  logic unused_addr_bits;
  assign if_bad = 1'b0;
  assign d_bad  = 1'b0;
  assign unused_addr_bits = ^{bus.if_addr[1:0], bus.if_addr[DATA_W-1:ADDR_W+2],
                              bus.d_addr[1:0],  bus.d_addr[DATA_W-1:ADDR_W+2]};
`endif

  // A requester seen completing this cycle is ignored; nothing issues in the cycle after reset release.
  assign i_try = rst_n && armed_q && (state_q != BUSY_I) && bus.if_req;
  assign d_try = rst_n && armed_q && (state_q != BUSY_D) && bus.d_req;

  // Grant, next state and memory-port shadow update.
  always_comb begin
    state_d  = IDLE;
    last_d   = last_q;
    addr_d   = addr_q;
    din_d    = din_q;
    d_we_d   = d_we_q;
    err_d    = err_q;
    mem_we_c = 1'b0;
    grant_i  = i_try && !(d_try && (last_q == GRANT_I));
    grant_d  = d_try && !grant_i;
    if (grant_i) begin
      state_d = BUSY_I;
      last_d  = GRANT_I;
      err_d   = if_bad;
      if (!if_bad) addr_d = bus.if_addr[ADDR_W+1:2];
    end else if (grant_d) begin
      state_d = BUSY_D;
      last_d  = GRANT_D;
      err_d   = d_bad;
      d_we_d  = bus.d_we;
      if (!d_bad) begin
        addr_d = bus.d_addr[ADDR_W+1:2];
        if (bus.d_we) begin
          mem_we_c = 1'b1;
          din_d    = bus.d_wdata;
        end
      end
    end
  end

  assign i_resp = rst_n && (state_q == BUSY_I);
  assign d_resp = rst_n && (state_q == BUSY_D);

  // Port drive; everything reads as zero while reset is asserted.
  always_comb begin
    bus.mem_we   = mem_we_c;
    bus.mem_addr = rst_n ? addr_d : '0;
    bus.mem_din  = rst_n ? din_d  : '0;
    bus.if_valid = i_resp;
    bus.if_err   = i_resp && err_q;
    bus.if_data  = (i_resp && !err_q) ? bus.mem_dout : '0;
    bus.d_valid  = d_resp;
    bus.d_err    = d_resp && err_q;
    bus.d_rdata  = (d_resp && !err_q && !d_we_q) ? bus.mem_dout : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= GRANT_I;
      armed_q <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      d_we_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      armed_q <= 1'b1;
      addr_q  <= addr_d;
      din_q   <= din_d;
      d_we_q  <= d_we_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized bench for mem_port_arbiter with a behavioural memory and
// a transaction-level reference model (expected data, latency bound, one write per store).
module tb_mem_port_arbiter;
  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  mem_port_if #(.ADDR_W(ADDR_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int unsigned w);
    if (w == 4) return 32'h2402_0005;
    return 32'h5A00_0000 ^ (w * 32'h0001_0001);
  endfunction

  // Single-port memory with one-cycle registered read.
  logic [31:0] mem [DEPTH];
  bit          written [DEPTH];
  always @(posedge clk) begin
    if (bus.mem_we) begin
      mem[bus.mem_addr]     <= bus.mem_din;
      written[bus.mem_addr] <= 1'b1;
    end
    bus.mem_dout <= written[bus.mem_addr] ? mem[bus.mem_addr] : init_val(32'(bus.mem_addr));
  end

  // Reference view of memory contents.
  logic [31:0] ref_mem [int unsigned];
  function automatic logic [31:0] ref_rd(input int unsigned w);
    return ref_mem.exists(w) ? ref_mem[w] : init_val(w);
  endfunction

  function automatic int unsigned word_of(input logic [31:0] a);
    return (a >> 2) % DEPTH;
  endfunction

  function automatic bit bad_addr(input logic [31:0] a);
`ifdef MEM_ADDR_CHECK_EN
    return ((a & 32'd3) != 0) || ((a >> (ADDR_W + 2)) != 0);
`else
    return (a & 32'd0) != 0;
`endif
  endfunction

  function automatic logic [31:0] gen_addr(input int unsigned lo_w, input int unsigned hi_w);
    logic [31:0] a;
    a = 32'($urandom_range(hi_w, lo_w)) << 2;
    if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(3, 1));
    if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(255, 1)) << (ADDR_W + 2));
    return a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ctl"}, 32'({bus.if_valid, bus.if_err, bus.d_valid, bus.d_err, bus.mem_we}), 32'd0);
    chk({tag, "_maddr"}, 32'(bus.mem_addr), 32'd0);
    chk({tag, "_mdin"}, bus.mem_din, 32'd0);
    chk({tag, "_idata"}, bus.if_data, 32'd0);
    chk({tag, "_drdata"}, bus.d_rdata, 32'd0);
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] dd);
    bus.if_req  = ir;
    bus.if_addr = ia;
    bus.d_req   = dr;
    bus.d_we    = dw;
    bus.d_addr  = da;
    bus.d_wdata = dd;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  bit          ia, da, dwe;
  logic [31:0] iaddr, daddr, dwd;
  int          iwait, dwait, dwrites, vcount;

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) begin next_cyc(); samp(); chk_quiet("in_reset"); end

    // Release cycle is quiet even with a request pending; the fetch then issues and returns.
    next_cyc(); rst_n = 1'b1; drive(1, 32'h10, 0, 0, 0, 0);
    samp(); chk_quiet("release");
    next_cyc(); samp();
    chk("fetch_maddr", 32'(bus.mem_addr), 32'd4);
    chk("fetch_we", 32'(bus.mem_we), 32'd0);
    chk("fetch_early", 32'(bus.if_valid), 32'd0);
    next_cyc(); samp();
    chk("fetch_valid", 32'(bus.if_valid), 32'd1);
    chk("fetch_data", bus.if_data, 32'h2402_0005);
    chk("fetch_err", 32'(bus.if_err), 32'd0);
    next_cyc(); drive(0, 0, 0, 0, 0, 0); samp();
    chk("fetch_pulse", 32'(bus.if_valid), 32'd0);

    // Store then load of the same word.
    next_cyc(); drive(0, 0, 1, 1, 32'h40, 32'hDEAD_BEEF); samp();
    chk("st_we", 32'(bus.mem_we), 32'd1);
    chk("st_maddr", 32'(bus.mem_addr), 32'd16);
    chk("st_din", bus.mem_din, 32'hDEAD_BEEF);
    next_cyc(); samp();
    chk("st_valid", 32'(bus.d_valid), 32'd1);
    chk("st_rdata", bus.d_rdata, 32'd0);
    chk("st_we_once", 32'(bus.mem_we), 32'd0);
    ref_mem[16] = 32'hDEAD_BEEF;
    next_cyc(); drive(0, 0, 1, 0, 32'h40, 0); samp();
    chk("ld_we", 32'(bus.mem_we), 32'd0);
    chk("ld_maddr", 32'(bus.mem_addr), 32'd16);
    chk("ld_early", 32'(bus.d_valid), 32'd0);
    next_cyc(); samp();
    chk("ld_valid", 32'(bus.d_valid), 32'd1);
    chk("ld_rdata", bus.d_rdata, 32'hDEAD_BEEF);
    next_cyc(); drive(0, 0, 0, 0, 0, 0); samp();
    chk("ld_pulse", 32'(bus.d_valid), 32'd0);

    // Simultaneous requests after reset: D wins the first tie.
    next_cyc(); rst_n = 1'b0; samp(); chk_quiet("rst2");
    next_cyc(); rst_n = 1'b1; samp(); chk_quiet("rel2");
    next_cyc(); drive(1, 32'h20, 1, 0, 32'h44, 0); samp();
    chk("tie_first", 32'(bus.mem_addr), 32'd17);
    next_cyc(); samp();
    chk("tie_dvalid", 32'(bus.d_valid), 32'd1);
    chk("tie_drdata", bus.d_rdata, init_val(17));
    chk("tie_second", 32'(bus.mem_addr), 32'd8);
    chk("tie_ivalid_early", 32'(bus.if_valid), 32'd0);
    next_cyc(); drive(1, 32'h20, 0, 0, 0, 0); samp();
    chk("tie_ivalid", 32'(bus.if_valid), 32'd1);
    chk("tie_idata", bus.if_data, init_val(8));
    chk("tie_dpulse", 32'(bus.d_valid), 32'd0);
    next_cyc(); drive(0, 0, 0, 0, 0, 0); samp();

    // Both requesters streaming: alternating issues, one completion per cycle.
    vcount = 0;
    for (int k = 0; k < 12; k++) begin
      next_cyc();
      if (k < 10) drive(1, 32'h30, 1, 0, 32'h48, 0);
      else        drive(0, 0, 0, 0, 0, 0);
      samp();
      if (k < 10) chk("stream_addr", 32'(bus.mem_addr), (k % 2 == 0) ? 32'd18 : 32'd12);
      if (k >= 1 && k <= 10) chk("stream_one", 32'(bus.if_valid) + 32'(bus.d_valid), 32'd1);
      if (bus.d_valid)  chk("stream_ddata", bus.d_rdata, init_val(18));
      if (bus.if_valid) chk("stream_idata", bus.if_data, init_val(12));
      vcount += int'(bus.if_valid) + int'(bus.d_valid);
    end
    chk("stream_total", 32'(vcount), 32'd10);

    // Reset while a load is in flight: its completion is dropped.
    next_cyc(); drive(0, 0, 1, 0, 32'h4C, 0); samp();
    chk("flight_issue", 32'(bus.mem_addr), 32'd19);
    next_cyc(); rst_n = 1'b0; drive(0, 0, 0, 0, 0, 0); samp(); chk_quiet("flight_rst");
    next_cyc(); rst_n = 1'b1; drive(1, 32'h14, 0, 0, 0, 0); samp(); chk_quiet("flight_rel");
    next_cyc(); samp();
    chk("after_rst_issue", 32'(bus.mem_addr), 32'd5);
    chk("after_rst_nodv", 32'(bus.d_valid), 32'd0);
    next_cyc(); samp();
    chk("after_rst_valid", 32'(bus.if_valid), 32'd1);
    chk("after_rst_data", bus.if_data, init_val(5));
    next_cyc(); drive(0, 0, 0, 0, 0, 0); samp();

    // Misaligned load.
    next_cyc(); drive(0, 0, 1, 0, 32'h42, 0); samp();
    chk("mis_we", 32'(bus.mem_we), 32'd0);
`ifndef MEM_ADDR_CHECK_EN
    chk("mis_maddr", 32'(bus.mem_addr), 32'd16);
`endif
    next_cyc(); samp();
    chk("mis_valid", 32'(bus.d_valid), 32'd1);
`ifdef MEM_ADDR_CHECK_EN
    chk("mis_err", 32'(bus.d_err), 32'd1);
    chk("mis_rdata", bus.d_rdata, 32'd0);
`else
    chk("mis_err", 32'(bus.d_err), 32'd0);
    chk("mis_rdata", bus.d_rdata, 32'hDEAD_BEEF);
`endif
    next_cyc(); drive(0, 0, 0, 0, 0, 0); samp();

    // Randomized traffic: fetches from words 0..255, stores to 256..511, loads from 0..511.
    ia = 0; da = 0; dwe = 0; iaddr = 0; daddr = 0; dwd = 0; iwait = 0; dwait = 0; dwrites = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      next_cyc();
      if (cyc < 590 && !ia && $urandom_range(0, 3) != 0) begin
        ia = 1; iaddr = gen_addr(0, 255); iwait = 0;
      end
      if (cyc < 590 && !da && $urandom_range(0, 3) != 0) begin
        da = 1; dwe = 1'($urandom_range(0, 1)); dwd = $urandom; dwait = 0; dwrites = 0;
        daddr = dwe ? gen_addr(256, 511) : gen_addr(0, 511);
      end
      drive(ia, iaddr, da, dwe, daddr, dwd);
      samp();
      if (ia) iwait++;
      if (da) dwait++;
      if (bus.mem_we) begin
        chk("rnd_we_owner", 32'({da, dwe, dwrites == 0}), 32'd7);
        chk("rnd_we_addr", 32'(bus.mem_addr), 32'(word_of(daddr)));
        chk("rnd_we_din", bus.mem_din, dwd);
        dwrites++;
      end
      chk("rnd_excl", 32'(bus.if_valid & bus.d_valid), 32'd0);
      chk("rnd_i_stall", 32'(ia && iwait >= 4 && !bus.if_valid), 32'd0);
      chk("rnd_d_stall", 32'(da && dwait >= 4 && !bus.d_valid), 32'd0);
      if (bus.if_valid) begin
        chk("rnd_i_owner", 32'(ia), 32'd1);
        chk("rnd_i_err", 32'(bus.if_err), 32'(bad_addr(iaddr)));
        chk("rnd_i_data", bus.if_data, bad_addr(iaddr) ? 32'd0 : ref_rd(word_of(iaddr)));
        ia = 0;
      end
      if (bus.d_valid) begin
        chk("rnd_d_owner", 32'(da), 32'd1);
        chk("rnd_d_err", 32'(bus.d_err), 32'(bad_addr(daddr)));
        if (dwe) begin
          chk("rnd_st_rdata", bus.d_rdata, 32'd0);
          chk("rnd_st_writes", 32'(dwrites), bad_addr(daddr) ? 32'd0 : 32'd1);
          if (!bad_addr(daddr)) ref_mem[word_of(daddr)] = dwd;
        end else begin
          chk("rnd_ld_rdata", bus.d_rdata, bad_addr(daddr) ? 32'd0 : ref_rd(word_of(daddr)));
        end
        da = 0;
      end
    end
    chk("rnd_drain", 32'({ia, da}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
